fa_self_checker: RTL

FA_SELF_CHECKER -- requirements
Module: fa_self_checker

---
 rtl/fa_self_checker.sv | 118 +++++++++++
 1 files changed

// File: rtl/fa_self_checker.sv
// fa_self_checker: drives all eight {Ci,B,A} combinations into an external
// full adder, holds each for SETTLE+1 cycles, compares {Co,S} against the
// ideal full-adder response and reports the result of the run.
//
// Ports
//   Clock    in   sole clock, rising edge
//   Reset    in   synchronous active-high reset, aborts any run
//   Start    in   begin one exhaustive run (sampled in IDLE only)
//   A,B,Ci   out  operand / carry-in drive to the adder (registered)
//   Co,S     in   adder response under test
//   Busy     out  run in progress
//   Done     out  one-cycle pulse at the end of a completed run
//   Pass     out  last run had no mismatches
//   ErrCount out  mismatching vectors in the last/current run (0..8)
//   FailVec  out  {Ci,B,A} of the first mismatching vector
//   FailCoS  out  {Co,S} observed at the first mismatching vector
module fa_self_checker #(
  parameter int SETTLE = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  output logic       A,
  output logic       B,
  output logic       Ci,
  input  logic       Co,
  input  logic       S,
  output logic       Busy,
  output logic       Done,
  output logic       Pass,
  output logic [3:0] ErrCount,
  output logic [2:0] FailVec,
  output logic [1:0] FailCoS
);

  typedef enum logic [1:0] {IDLE, HOLD, CHECK, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] vec;
  logic [3:0] cnt;
  logic [1:0] obs_cos;
  logic [1:0] exp_cos;
  logic       mism;

  // Ideal full-adder response for a {Ci,B,A} vector, packed as {Co,S}.
  function automatic logic [1:0] fa_expect(input logic [2:0] v);
    logic co, s;
    co = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    s  = v[0] ^ v[1] ^ v[2];
    return {co, s};
  endfunction

  assign {Ci, B, A} = vec;
  assign obs_cos    = {Co, S};
  assign exp_cos    = fa_expect(vec);
  // Case equality so that an X or Z from the adder counts as a mismatch.
  assign mism       = (obs_cos === exp_cos) ? 1'b0 : 1'b1;

  assign Busy = (state == HOLD) || (state == CHECK);
  assign Done = (state == DONE);

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = HOLD;
      HOLD:    if (cnt == 4'(SETTLE - 1)) state_nxt = CHECK;
      CHECK:   state_nxt = (vec == 3'd7) ? DONE : HOLD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      vec      <= '0;
      cnt      <= '0;
      Pass     <= 1'b0;
      ErrCount <= '0;
      FailVec  <= '0;
      FailCoS  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            vec      <= '0;
            cnt      <= '0;
            Pass     <= 1'b0;
            ErrCount <= '0;
            FailVec  <= '0;
            FailCoS  <= '0;
          end
        end
        HOLD: cnt <= cnt + 4'd1;
        CHECK: begin
          cnt <= '0;
          if (mism) begin
            ErrCount <= ErrCount + 4'd1;
            // Only the first failure of the run is recorded.
            if (ErrCount == 4'd0) begin
              FailVec <= vec;
              FailCoS <= obs_cos;
            end
          end
          // vec stops at 7 so the last vector stays on the pins afterwards.
          if (vec != 3'd7) vec <= vec + 3'd1;
          else             Pass <= (ErrCount == 4'd0) && !mism;
        end
        default: ;
      endcase
    end
  end

endmodule
